// File: rtl/input_stream_buffer.sv
// input_stream_buffer
//   Per-lane row buffer feeding the west edge of the block-multiply systolic
//   array. A DEPTH-element row is loaded per lane through a valid/ready write
//   port; after start, each lane streams its row one element per cycle once
//   its lane_go bit has been seen. lane_go comes from control_mux and staggers
//   the lane start times to skew the input wavefront.
//
// Handshake: a write is transferred on a rising clock edge where
//   wr_valid & wr_ready are both high. wr_ready is combinational from state,
//   wr_lane and that lane's write pointer, and is only ever high in LOAD.
//   Writes that are not accepted are dropped, not held.
//
// Ports
//   clock       in   1         rising-edge clock
//   reset       in   1         synchronous, active-low reset
//   wr_valid    in   1         write request
//   wr_ready    out  1         write accepted when wr_valid & wr_ready
//   wr_lane     in   clog2(LANES)  target lane of write
//   wr_data     in   DW        element appended at the lane's write pointer
//   start       in   1         begin streaming (sampled in LOAD only)
//   lane_go     in   LANES     per-lane start enable
//   lane_data   out  LANES*DW  lane i at [i*DW +: DW], registered
//   lane_valid  out  LANES     lane i element on lane_data is real
//   busy        out  1         high in STREAM and DONE
//   done        out  1         one-cycle pulse, all lanes drained
//   state_dbg   out  2         current FSM state (LOAD=0, STREAM=1, DONE=2)
//
// DEPTH must be at least 2.

module input_stream_buffer #(
    parameter int LANES = 4,
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(LANES)-1:0] wr_lane,
    input  logic [DW-1:0]            wr_data,
    input  logic                     start,
    input  logic [LANES-1:0]         lane_go,
    output logic [LANES*DW-1:0]      lane_data,
    output logic [LANES-1:0]         lane_valid,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               state_dbg
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] FULL = PW'(DEPTH);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t state, next_state;

    logic [DW-1:0]    mem     [LANES][DEPTH];
    logic [PW-1:0]    wr_ptr  [LANES];
    logic [PW-1:0]    rd_ptr  [LANES];
    logic [LANES-1:0] started;
    logic             all_drained;

    assign busy      = (state != ST_LOAD);
    assign done      = (state == ST_DONE);
    assign state_dbg = state;

    // Out-of-range lanes and full lanes never raise ready, so their writes drop.
    always_comb begin
        wr_ready = 1'b0;
        if (state == ST_LOAD && int'(wr_lane) < LANES)
            wr_ready = (wr_ptr[wr_lane] != FULL);
    end

    always_comb begin
        all_drained = 1'b1;
        for (int i = 0; i < LANES; i++)
            if (rd_ptr[i] != FULL)
                all_drained = 1'b0;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_LOAD:   if (start) next_state = ST_STREAM;
            ST_STREAM: if (all_drained) next_state = ST_DONE;
            ST_DONE:   next_state = ST_LOAD;
            default:   next_state = ST_LOAD;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state <= ST_LOAD;
        else        state <= next_state;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < LANES; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                for (int j = 0; j < DEPTH; j++)
                    mem[i][j] <= '0;
            end
            started    <= '0;
            lane_data  <= '0;
            lane_valid <= '0;
        end else begin
            // Outputs idle unless a lane emits below.
            lane_data  <= '0;
            lane_valid <= '0;

            // A write in the same cycle as start still lands before streaming.
            if (wr_valid && wr_ready) begin
                mem[wr_lane][wr_ptr[wr_lane][AW-1:0]] <= wr_data;
                wr_ptr[wr_lane] <= wr_ptr[wr_lane] + PW'(1);
            end

            if (state == ST_STREAM) begin
                for (int i = 0; i < LANES; i++) begin
                    // lane_go counts only until the lane has started; after
                    // that the row runs to completion regardless of lane_go.
                    if ((started[i] || lane_go[i]) && rd_ptr[i] != FULL) begin
                        started[i]            <= 1'b1;
                        lane_data[i*DW +: DW] <= mem[i][rd_ptr[i][AW-1:0]];
                        lane_valid[i]         <= 1'b1;
                        rd_ptr[i]             <= rd_ptr[i] + PW'(1);
                    end
                end
            end

            if (state == ST_DONE) begin
                for (int i = 0; i < LANES; i++) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                    for (int j = 0; j < DEPTH; j++)
                        mem[i][j] <= '0;
                end
                started <= '0;
            end
        end
    end

endmodule
